// File: rtl/dphy_delay_calib.sv
// rtl/dphy_delay_calib.sv - per-lane IDELAY eye-scan and centring controller
//
// Steps the lane input delay through all 32 taps, counts PATTERN hits per tap
// to build a pass map, then seeks the delay to the centre of the longest
// passing run.
//
// Ports:
//   byte_clk_i   in   byte clock, all logic synchronous to it
//   rst_n_i      in   asynchronous active-low reset
//   start_i      in   1-cycle calibration request, ignored while busy
//   hs_valid_i   in   byte_data_i carries HS payload this cycle
//   byte_data_i  in   deserialised lane byte
//   cur_delay_i  in   current tap read back from the delay element
//   inc_delay_o  out  1-cycle pulse: delay +1 tap
//   busy_o       out  calibration in progress
//   locked_o     out  last calibration succeeded
//   fail_o       out  last calibration found no passing tap
//   eye_start_o  out  first tap of the chosen passing run
//   eye_len_o    out  length of the chosen run
module dphy_delay_calib #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned WINDOW        = 256,
    parameter int unsigned MIN_HITS      = 4,
    parameter logic [7:0]  PATTERN       = 8'hB8
) (
    input  logic       byte_clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic       hs_valid_i,
    input  logic [7:0] byte_data_i,
    input  logic [4:0] cur_delay_i,
    output logic       inc_delay_o,
    output logic       busy_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [4:0] eye_start_o,
    output logic [5:0] eye_len_o
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] WINDOW_MAX  = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] MIN_HITS_C  = CNT_W'(MIN_HITS);

    typedef enum logic [3:0] {
        ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_STEP, ST_EVAL,
        ST_SEEK_CMP, ST_SEEK_INC, ST_SEEK_WAIT, ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [4:0]       tap_q, tap_d;
    logic [31:0]      map_q, map_d;
    logic [4:0]       scan_q, scan_d;
    logic [4:0]       run_start_q, run_start_d;
    logic [5:0]       run_len_q, run_len_d;
    logic [4:0]       best_start_q, best_start_d;
    logic [5:0]       best_len_q, best_len_d;
    logic [4:0]       target_q, target_d;
    logic             inc_q, inc_d;
    logic             busy_q, busy_d;
    logic             locked_q, locked_d;
    logic             fail_q, fail_d;
    logic [4:0]       eye_start_q, eye_start_d;
    logic [5:0]       eye_len_q, eye_len_d;

    logic             hit_now;
    logic [CNT_W-1:0] hit_sum;
    logic [4:0]       run_start_n;
    logic [5:0]       run_len_n;
    logic [4:0]       best_start_n;
    logic [5:0]       best_len_n;
    logic [5:0]       half_len;

    always_comb begin
        hit_now = hs_valid_i && (byte_data_i == PATTERN);
        hit_sum = (hit_q == WINDOW_MAX) ? hit_q : hit_q + {{(CNT_W-1){1'b0}}, hit_now};

        // Run tracking for the serial scan. Best is replaced only on a strictly
        // longer run, so equal-length runs keep the lowest start tap.
        if (map_q[scan_q]) begin
            run_start_n = (run_len_q == 6'd0) ? scan_q : run_start_q;
            run_len_n   = run_len_q + 6'd1;
        end else begin
            run_start_n = run_start_q;
            run_len_n   = 6'd0;
        end
        if (run_len_n > best_len_q) begin
            best_start_n = run_start_n;
            best_len_n   = run_len_n;
        end else begin
            best_start_n = best_start_q;
            best_len_n   = best_len_q;
        end
        half_len = (best_len_n - 6'd1) >> 1;

        state_d      = state_q;
        cnt_d        = cnt_q;
        hit_d        = hit_q;
        tap_d        = tap_q;
        map_d        = map_q;
        scan_d       = scan_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        target_d     = target_q;
        inc_d        = 1'b0;
        busy_d       = busy_q;
        locked_d     = locked_q;
        fail_d       = fail_q;
        eye_start_d  = eye_start_q;
        eye_len_d    = eye_len_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_SETTLE;
                    busy_d   = 1'b1;
                    locked_d = 1'b0;
                    fail_d   = 1'b0;
                    tap_d    = 5'd0;
                    cnt_d    = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                    hit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                cnt_d = cnt_q + 1'b1;
                hit_d = hit_sum;
                if (cnt_q == WINDOW_LAST) begin
                    // Include this cycle's hit in the pass decision.
                    map_d[cur_delay_i] = (hit_sum >= MIN_HITS_C);
                    state_d = ST_STEP;
                    inc_d   = 1'b1;
                end
            end
            ST_STEP: begin
                tap_d = tap_q + 5'd1;
                if (tap_q == 5'd31) begin
                    state_d      = ST_EVAL;
                    scan_d       = 5'd0;
                    run_start_d  = 5'd0;
                    run_len_d    = 6'd0;
                    best_start_d = 5'd0;
                    best_len_d   = 6'd0;
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_EVAL: begin
                scan_d       = scan_q + 5'd1;
                run_start_d  = run_start_n;
                run_len_d    = run_len_n;
                best_start_d = best_start_n;
                best_len_d   = best_len_n;
                if (scan_q == 5'd31) begin
                    if (best_len_n == 6'd0) begin
                        fail_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        eye_start_d = best_start_n;
                        eye_len_d   = best_len_n;
                        target_d    = best_start_n + half_len[4:0];
                        state_d     = ST_SEEK_CMP;
                    end
                end
            end
            ST_SEEK_CMP: begin
                if (cur_delay_i == target_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SEEK_INC;
                    inc_d   = 1'b1;
                end
            end
            ST_SEEK_INC: begin
                state_d = ST_SEEK_WAIT;
                cnt_d   = '0;
            end
            ST_SEEK_WAIT: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SEEK_CMP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                locked_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hit_q        <= '0;
            tap_q        <= 5'd0;
            map_q        <= 32'd0;
            scan_q       <= 5'd0;
            run_start_q  <= 5'd0;
            run_len_q    <= 6'd0;
            best_start_q <= 5'd0;
            best_len_q   <= 6'd0;
            target_q     <= 5'd0;
            inc_q        <= 1'b0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            eye_start_q  <= 5'd0;
            eye_len_q    <= 6'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hit_q        <= hit_d;
            tap_q        <= tap_d;
            map_q        <= map_d;
            scan_q       <= scan_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            target_q     <= target_d;
            inc_q        <= inc_d;
            busy_q       <= busy_d;
            locked_q     <= locked_d;
            fail_q       <= fail_d;
            eye_start_q  <= eye_start_d;
            eye_len_q    <= eye_len_d;
        end
    end

    assign inc_delay_o = inc_q;
    assign busy_o      = busy_q;
    assign locked_o    = locked_q;
    assign fail_o      = fail_q;
    assign eye_start_o = eye_start_q;
    assign eye_len_o   = eye_len_q;

endmodule

// File: tb/tb_dphy_delay_calib.sv
// tb/tb_dphy_delay_calib.sv - bench for dphy_delay_calib with delay-element and lane model
module tb_dphy_delay_calib;

    localparam logic [7:0] PAT      = 8'hB8;
    localparam int         MIN_HITS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hs_valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic [4:0] cur = 5'd0;
    logic       inc, busy, locked, fail;
    logic [4:0] eye_start;
    logic [5:0] eye_len;

    always #5 clk = ~clk;

    dphy_delay_calib dut (
        .byte_clk_i  (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .hs_valid_i  (hs_valid),
        .byte_data_i (data),
        .cur_delay_i (cur),
        .inc_delay_o (inc),
        .busy_o      (busy),
        .locked_o    (locked),
        .fail_o      (fail),
        .eye_start_o (eye_start),
        .eye_len_o   (eye_len)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Lane model: per tap, how many pattern bytes appear in the window and
    // whether they are flagged as HS-valid.
    int   hits[32];
    bit   vok[32];
    logic set_req = 1'b0;
    logic [4:0] set_val = 5'd0;
    int   k = 0;
    int   pulse_cnt = 0;
    int   consec_err = 0;
    int   idle_inc_err = 0;
    logic prev_inc = 1'b0;

    // Delay element model plus pulse monitors.
    always @(posedge clk) begin
        if (set_req)  cur <= set_val;
        else if (inc) cur <= cur + 5'd1;
        if (inc) pulse_cnt <= pulse_cnt + 1;
        if (inc && prev_inc) consec_err <= consec_err + 1;
        if (inc && !busy) idle_inc_err <= idle_inc_err + 1;
        prev_inc <= inc;
        if (inc || (start && !busy)) k <= 0;
        else k <= k + 1;
    end

    // Hits placed well inside the sample window of each tap (k counts cycles
    // since the tap last changed).
    always @(negedge clk) begin : drv
        logic [7:0] d;
        if (k >= 30 && (k - 30) % 10 == 0 && (k - 30) / 10 < hits[cur]) begin
            data     <= PAT;
            hs_valid <= vok[cur];
        end else if ($urandom_range(0, 7) == 0) begin
            data     <= PAT;
            hs_valid <= 1'b0;
        end else begin
            d = 8'($urandom_range(0, 254));
            if (d >= PAT) d = d + 8'd1;
            data     <= d;
            hs_valid <= 1'($urandom_range(0, 1));
        end
    end

    function automatic bit passes(input int t);
        return vok[t] && hits[t] >= MIN_HITS;
    endfunction

    // Longest non-wrapping run of passing taps, lowest start on ties.
    task automatic ref_eye(output int s, output int l);
        s = 0;
        l = 0;
        for (int a = 0; a < 32; a++) begin
            int n = 0;
            while (a + n < 32 && passes(a + n)) n++;
            if (n > l) begin
                l = n;
                s = a;
            end
        end
    endtask

    task automatic clear_cfg();
        for (int t = 0; t < 32; t++) begin
            hits[t] = 0;
            vok[t]  = 1'b1;
        end
    endtask

    task automatic set_pass(input int lo, input int hi);
        for (int t = lo; t <= hi; t++) hits[t] = $urandom_range(MIN_HITS, 20);
    endtask

    task automatic run_cal(input string tag, input int init, input int restart_at);
        int s, l, tgt, exp_pulses, p0, cyc;
        bit exp_fail;
        ref_eye(s, l);
        exp_fail   = (l == 0);
        tgt        = exp_fail ? init : (s + (l - 1) / 2) % 32;
        exp_pulses = 32 + (exp_fail ? 0 : (tgt - init + 32) % 32);
        @(negedge clk);
        set_req = 1'b1;
        set_val = 5'(init);
        @(negedge clk);
        set_req = 1'b0;
        p0 = pulse_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        cyc = 0;
        while (busy && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
        end
        start = 1'b0;
        chk({tag, "_timeout"}, busy, 0);
        chk({tag, "_fail"}, fail, exp_fail);
        chk({tag, "_locked"}, locked, !exp_fail);
        chk({tag, "_pulses"}, pulse_cnt - p0, exp_pulses);
        chk({tag, "_tap"}, cur, tgt);
        if (!exp_fail) begin
            chk({tag, "_eye_start"}, eye_start, s);
            chk({tag, "_eye_len"}, eye_len, l);
        end
        repeat (3) @(negedge clk);
        chk({tag, "_idle_stable"}, busy, 0);
    endtask

    initial begin
        int cyc, p0;
        clear_cfg();
        repeat (3) @(negedge clk);
        chk("rst_inc", inc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fail", fail, 0);
        chk("rst_eye_start", eye_start, 0);
        chk("rst_eye_len", eye_len, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: passing taps 10..19
        clear_cfg();
        set_pass(10, 19);
        run_cal("c1", 0, 0);

        // 2: nothing passes
        clear_cfg();
        run_cal("c2", 0, 0);

        // 3: two equal runs, seek wraps from 20 through 31->0 to 3
        clear_cfg();
        set_pass(2, 5);
        set_pass(25, 28);
        run_cal("c3", 20, 0);

        // 4: hit threshold boundary
        clear_cfg();
        hits[7] = 3;
        hits[8] = 4;
        run_cal("c4", 0, 0);

        // 5: hits only with hs_valid low, plus a start pulse while busy
        clear_cfg();
        hits[9] = 20;
        vok[9]  = 1'b0;
        run_cal("c5", 0, 500);

        // 6: reset during SAMPLE at tap 5, then a fresh full run
        clear_cfg();
        set_pass(10, 19);
        @(negedge clk);
        set_req = 1'b1;
        set_val = 5'd0;
        @(negedge clk);
        set_req = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(cur == 5'd5 && k == 100) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("c6_reach_tap5", cur, 5);
        p0 = pulse_cnt;
        rst_n = 1'b0;
        #1;
        chk("c6_rst_inc", inc, 0);
        chk("c6_rst_busy", busy, 0);
        chk("c6_rst_locked", locked, 0);
        chk("c6_rst_fail", fail, 0);
        repeat (3) @(negedge clk);
        chk("c6_rst_pulses", pulse_cnt - p0, 0);
        chk("c6_rst_tap", cur, 5);
        rst_n = 1'b1;
        @(negedge clk);
        run_cal("c6b", 5, 0);

        // Random pass map and initial tap
        clear_cfg();
        for (int t = 0; t < 32; t++) begin
            hits[t] = $urandom_range(0, 20);
            vok[t]  = ($urandom_range(0, 3) != 0);
        end
        run_cal("rnd", $urandom_range(0, 31), 0);

        chk("inc_consecutive", consec_err, 0);
        chk("inc_while_idle", idle_inc_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
